// File: rtl/dlx_pkg.sv
// Shared DLX peripheral definitions: LED register bit positions and the
// access-handshake state type used by the LED controller.
package dlx_pkg;

  localparam int LED_BLINK_BIT = 16;
  localparam int LED_PHASE_BIT = 17;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } led_state_t;

endpackage

// File: rtl/led_ctrl_prescaler.sv
// Blink prescaler: counts 0..PRESCALE-1 while enabled and toggles phase on
// each wrap. Disabled or cleared, it parks at count 0 with phase high so the
// LED pattern is shown.
module led_prescaler #(
  parameter int PRESCALE = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic phase
);

  localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  // Half-period counter with phase toggle at the terminal count.
  always_ff @(posedge clk) begin
    if (rst || clear || !enable) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_ctrl.sv
// Memory-mapped LED controller with a one-wait-state access handshake.
// Optional blink feature enabled by defining LED_CTRL_BLINK_EN; without it the
// LEDs show the written pattern steadily and register bits 17:16 read 0.
module led_ctrl
  import dlx_pkg::*;
#(
  parameter int N_LEDS   = 8,
  parameter int PRESCALE = 25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_led,
  input  logic              we,
  input  logic              re,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [N_LEDS-1:0] leds
);

  led_state_t        state;
  logic              rd_q;
  logic [N_LEDS-1:0] pattern;
  logic              blink_en;
  logic              phase;
  logic              start;
  logic              wr_start;

  assign start    = (state == IDLE) && cs_led && (we || re);
  assign wr_start = start && we;

  // Handshake FSM and pattern register; strobes are ignored while in ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_q    <= 1'b0;
      pattern <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACK;
            rd_q  <= re;
          end
          if (wr_start) begin
            pattern <= wdata[N_LEDS-1:0];
          end
        end
        default: begin
          state <= IDLE;
          rd_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LED_CTRL_BLINK_EN
  // Blink enable register; a write always restarts the blink cycle in the on phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_en <= 1'b0;
    end else if (wr_start) begin
      blink_en <= wdata[LED_BLINK_BIT];
    end
  end

  led_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (blink_en),
    .clear  (wr_start),
    .phase  (phase)
  );

  // LED drive: pattern gated by the blink phase when blinking; dark during reset.
  always_comb begin
    leds = pattern;
    if (blink_en) leds = pattern & {N_LEDS{phase}};
    if (rst) leds = '0;
  end
`else
  assign blink_en = 1'b0;
  assign phase    = 1'b0;

  // LED drive: steady pattern; dark during reset.
  always_comb begin
    leds = pattern;
    if (rst) leds = '0;
  end
`endif

  // Ready and read data exist only in ACK; reset drops an in-flight access.
  always_comb begin
    ready = (state == ACK) && !rst;
    rdata = '0;
    if (ready && rd_q) begin
      rdata[N_LEDS-1:0]    = pattern;
      rdata[LED_BLINK_BIT] = blink_en;
      rdata[LED_PHASE_BIT] = phase;
    end
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Directed self-checking bench for led_ctrl (N_LEDS=8, PRESCALE=4).
// Blink expectations apply when LED_CTRL_BLINK_EN is defined.
module tb_led_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_led;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [7:0]  leds;

  int n_cmp = 0;
  int n_err = 0;

  led_ctrl #(
    .N_LEDS   (8),
    .PRESCALE (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cs_led (cs_led),
    .we     (we),
    .re     (re),
    .wdata  (wdata),
    .rdata  (rdata),
    .ready  (ready),
    .leds   (leds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample outputs at the falling edge of the current cycle.
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    cs_led = 1'b0;
    we     = 1'b0;
    re     = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_rb;
    rst = 1'b1;
    idle_bus();
    wdata = 32'h0;

    // Reset held two cycles.
    tick();
    tick();
    sample();
    chk("rst_leds", {24'h0, leds}, 32'h0);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    tick();
    rst = 1'b0;
    sample();
    chk("post_rst_leds", {24'h0, leds}, 32'h0);

    // Write 0xA5.
    tick();
    cs_led = 1'b1; we = 1'b1; wdata = 32'h0000_00A5;
    sample();
    chk("wr_start_ready", {31'h0, ready}, 32'h0);
    tick();
    idle_bus();
    sample();
    chk("wr_ack_ready", {31'h0, ready}, 32'h1);
    chk("wr_ack_leds", {24'h0, leds}, 32'hA5);
    chk("wr_ack_rdata", rdata, 32'h0);
    tick();
    sample();
    chk("wr_after_ready", {31'h0, ready}, 32'h0);

    // Read back.
`ifdef LED_CTRL_BLINK_EN
    exp_rb = 32'h0002_00A5;
`else
    exp_rb = 32'h0000_00A5;
`endif
    tick();
    cs_led = 1'b1; re = 1'b1;
    sample();
    chk("rd_start_ready", {31'h0, ready}, 32'h0);
    chk("rd_start_rdata", rdata, 32'h0);
    tick();
    idle_bus();
    sample();
    chk("rd_ack_ready", {31'h0, ready}, 32'h1);
    chk("rd_ack_rdata", rdata, exp_rb);
    tick();
    sample();
    chk("rd_after_rdata", rdata, 32'h0);

    // Deselected write strobe is ignored.
    tick();
    we = 1'b1; wdata = 32'h0000_003C;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("desel_ready", {31'h0, ready}, 32'h0);
      chk("desel_leds", {24'h0, leds}, 32'hA5);
      tick();
    end
    idle_bus();

    // Held strobe: ready 0,1,0,1.
    cs_led = 1'b1; we = 1'b1; wdata = 32'h0000_005A;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) idle_bus();
      sample();
      chk($sformatf("held_ready_%0d", k), {31'h0, ready}, (k % 2 == 1) ? 32'h1 : 32'h0);
      tick();
    end
    sample();
    chk("held_after_ready", {31'h0, ready}, 32'h0);
    chk("held_leds", {24'h0, leds}, 32'h5A);

    // Blink pattern write.
    tick();
    cs_led = 1'b1; we = 1'b1; wdata = 32'h0001_00FF;
    tick();
    idle_bus();
`ifdef LED_CTRL_BLINK_EN
    // Cycle 0 is the ACK cycle; phase high for 4 cycles, low for 4.
    for (int k = 0; k < 12; k++) begin
      sample();
      chk($sformatf("blink_%0d", k), {24'h0, leds}, ((k / 4) % 2 == 0) ? 32'hFF : 32'h00);
      tick();
    end
    // Cycle 12 is in the off phase: rewrite restores the pattern at once.
    cs_led = 1'b1; we = 1'b1; wdata = 32'h0001_00FF;
    sample();
    chk("blink_off_leds", {24'h0, leds}, 32'h00);
    tick();
    idle_bus();
    sample();
    chk("blink_rewrite_leds", {24'h0, leds}, 32'hFF);
    tick();
    cs_led = 1'b1; re = 1'b1;
    tick();
    idle_bus();
    sample();
    chk("blink_rd_rdata", rdata, 32'h0003_00FF);
`else
    for (int k = 0; k < 10; k++) begin
      sample();
      chk($sformatf("steady_%0d", k), {24'h0, leds}, 32'hFF);
      tick();
    end
    cs_led = 1'b1; re = 1'b1;
    tick();
    idle_bus();
    sample();
    chk("steady_rd_rdata", rdata, 32'h0000_00FF);
`endif

    // Simultaneous write and read returns the post-write value.
`ifdef LED_CTRL_BLINK_EN
    exp_rb = 32'h0002_0033;
`else
    exp_rb = 32'h0000_0033;
`endif
    tick();
    cs_led = 1'b1; we = 1'b1; re = 1'b1; wdata = 32'h0000_0033;
    tick();
    idle_bus();
    sample();
    chk("wrrd_ready", {31'h0, ready}, 32'h1);
    chk("wrrd_rdata", rdata, exp_rb);
    chk("wrrd_leds", {24'h0, leds}, 32'h33);

    // Reset during ACK drops the access.
    tick();
    cs_led = 1'b1; we = 1'b1; wdata = 32'h0000_0077;
    tick();
    idle_bus();
    rst = 1'b1;
    sample();
    chk("rst_ack_ready", {31'h0, ready}, 32'h0);
    chk("rst_ack_leds", {24'h0, leds}, 32'h0);
    chk("rst_ack_rdata", rdata, 32'h0);
    tick();
    rst = 1'b0;
    sample();
    chk("rst_ack_after_ready", {31'h0, ready}, 32'h0);
    chk("rst_ack_after_leds", {24'h0, leds}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
